mips_lsu: RTL and testbench

//  Parametrised load/store unit for the MIPS pipeline M stage. Replaces the fixed single-cycle memory path.
//  - Adds variable-latency memory via a mem_ready handshake, with a timeout.
//  - Supports byte, halfword and word accesses, signed and unsigned, big-endian lanes.
//  - Tracks an LL/SC reservation that both local stores and an external snoop port can break.
//  - Holds busy high to stall the pipeline while an access is outstanding.

---
 rtl/mips_lsu.sv | 262 ++++++++++++++++++++++++++
 tb/tb_mips_lsu.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_lsu.sv
// Load/store unit for the MIPS M stage: variable-latency memory handshake with timeout,
// big-endian sub-word lanes, and an LL/SC reservation broken by local stores and snoops.
module mips_lsu #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned RESV_GRAN_LG = 2,
    parameter int unsigned TIMEOUT      = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              req_valid_i,
    input  logic              req_load_i,
    input  logic              req_store_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_signed_i,
    input  logic              req_ll_i,
    input  logic              req_sc_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    input  logic [4:0]        req_rd_i,
    output logic              busy_o,
    output logic              mem_read_en_o,
    output logic [3:0]        mem_write_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_write_data_o,
    input  logic [31:0]       mem_read_data_i,
    input  logic              mem_ready_i,
    input  logic              snoop_we_i,
    input  logic [ADDR_W-1:0] snoop_addr_i,
    output logic              resp_valid_o,
    output logic [31:0]       resp_data_o,
    output logic [4:0]        resp_rd_o,
    output logic              resp_err_o,
    output logic              resv_valid_o
);

    localparam int unsigned RA_W  = ADDR_W - RESV_GRAN_LG;
    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;

    state_e              state_q, state_d;
    logic                busy_q, busy_d;
    logic                mem_rd_q, mem_rd_d;
    logic [3:0]          mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                resp_valid_q, resp_valid_d;
    logic [31:0]         resp_data_q, resp_data_d;
    logic [4:0]          resp_rd_q, resp_rd_d;
    logic                resp_err_q, resp_err_d;
    logic                resv_valid_q, resv_valid_d;
    logic [RA_W-1:0]     resv_addr_q, resv_addr_d;
    logic                ld_q, ld_d;
    logic [1:0]          size_q, size_d;
    logic                sgn_q, sgn_d;
    logic                ll_q, ll_d;
    logic                sc_q, sc_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [4:0]          rd_q, rd_d;
    logic                mis_q, mis_d;
    logic                skip_q, skip_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic snoop_hit, req_hit, misalign, sc_fail, skip_req, tmo_hit;

    function automatic logic [RA_W-1:0] granule(input logic [ADDR_W-1:0] a);
        return RA_W'(a >> RESV_GRAN_LG);
    endfunction

    function automatic logic [3:0] lanes(input logic [1:0] size, input logic [1:0] off);
        if (size[1])      return 4'b1111;
        else if (size[0]) return off[1] ? 4'b0011 : 4'b1100;
        else              return 4'b1000 >> off;
    endfunction

    function automatic logic [31:0] wrep(input logic [1:0] size, input logic [31:0] w);
        if (size[1])      return w;
        else if (size[0]) return {2{w[15:0]}};
        else              return {4{w[7:0]}};
    endfunction

    // Offset 0 lives in bits 31:24 (big-endian lanes).
    function automatic logic [31:0] ld_fmt(input logic [31:0] d, input logic [1:0] size,
                                           input logic [1:0] off, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = d[31:24];
            2'd1:    b = d[23:16];
            2'd2:    b = d[15:8];
            default: b = d[7:0];
        endcase
        h = off[1] ? d[15:0] : d[31:16];
        if (size[1])      return d;
        else if (size[0]) return {{16{sgn & h[15]}}, h};
        else              return {{24{sgn & b[7]}}, b};
    endfunction

    assign snoop_hit = snoop_we_i & resv_valid_q & (granule(snoop_addr_i) == resv_addr_q);
    assign req_hit   = resv_valid_q & (granule(req_addr_i) == resv_addr_q);
    assign misalign  = req_size_i[1] ? (req_addr_i[1:0] != 2'b00) : (req_size_i[0] & req_addr_i[0]);
    assign sc_fail   = req_sc_i & ~(req_hit & ~snoop_hit);
    assign skip_req  = misalign | sc_fail | ~(req_load_i | req_store_i);
    assign tmo_hit   = (TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) >= TIMEOUT);

    // Next-state and registered-output logic; en_i low freezes everything.
    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        mem_rd_d     = mem_rd_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_rd_d    = resp_rd_q;
        resp_err_d   = resp_err_q;
        resv_valid_d = resv_valid_q;
        resv_addr_d  = resv_addr_q;
        ld_d         = ld_q;
        size_d       = size_q;
        sgn_d        = sgn_q;
        ll_d         = ll_q;
        sc_d         = sc_q;
        addr_d       = addr_q;
        rd_d         = rd_q;
        mis_d        = mis_q;
        skip_d       = skip_q;
        cnt_d        = cnt_q;
        if (en_i) begin
            if (snoop_hit) resv_valid_d = 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        state_d = S_ACCESS;
                        busy_d  = 1'b1;
                        cnt_d   = '0;
                        ld_d    = req_load_i;
                        size_d  = req_size_i;
                        sgn_d   = req_signed_i;
                        ll_d    = req_ll_i;
                        sc_d    = req_sc_i;
                        addr_d  = req_addr_i;
                        rd_d    = req_rd_i;
                        mis_d   = misalign;
                        skip_d  = skip_req;
                        // Faulted or failed requests pass one quiet cycle so all responses share the same minimum latency.
                        if (!skip_req) begin
                            mem_rd_d    = req_load_i;
                            mem_we_d    = req_store_i ? lanes(req_size_i, req_addr_i[1:0]) : 4'b0000;
                            mem_addr_d  = req_addr_i;
                            mem_wdata_d = req_store_i ? wrep(req_size_i, req_wdata_i) : 32'd0;
                            if (req_store_i && req_hit) resv_valid_d = 1'b0;
                        end
                    end
                end
                S_ACCESS: begin
                    if (skip_q || mem_ready_i || tmo_hit) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_rd_d    = rd_q;
                        mem_rd_d     = 1'b0;
                        mem_we_d     = 4'b0000;
                        mem_addr_d   = '0;
                        mem_wdata_d  = 32'd0;
                        if (sc_q && !mis_q) resv_valid_d = 1'b0;
                        if (skip_q) begin
                            resp_err_d  = mis_q;
                            resp_data_d = 32'd0;
                        end else if (mem_ready_i) begin
                            resp_err_d  = 1'b0;
                            resp_data_d = ld_q ? ld_fmt(mem_read_data_i, size_q, addr_q[1:0], sgn_q)
                                               : {31'd0, sc_q};
                            if (ll_q) begin
                                resv_valid_d = 1'b1;
                                resv_addr_d  = granule(addr_q);
                            end
                        end else begin
                            resp_err_d  = 1'b1;
                            resp_data_d = 32'd0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    state_d      = S_IDLE;
                    busy_d       = 1'b0;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q       <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_we_q     <= 4'b0000;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'd0;
            resp_rd_q    <= 5'd0;
            resp_err_q   <= 1'b0;
            resv_valid_q <= 1'b0;
            resv_addr_q  <= '0;
            ld_q         <= 1'b0;
            size_q       <= 2'd0;
            sgn_q        <= 1'b0;
            ll_q         <= 1'b0;
            sc_q         <= 1'b0;
            addr_q       <= '0;
            rd_q         <= 5'd0;
            mis_q        <= 1'b0;
            skip_q       <= 1'b0;
            cnt_q        <= '0;
        end else begin
            busy_q       <= busy_d;
            mem_rd_q     <= mem_rd_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_rd_q    <= resp_rd_d;
            resp_err_q   <= resp_err_d;
            resv_valid_q <= resv_valid_d;
            resv_addr_q  <= resv_addr_d;
            ld_q         <= ld_d;
            size_q       <= size_d;
            sgn_q        <= sgn_d;
            ll_q         <= ll_d;
            sc_q         <= sc_d;
            addr_q       <= addr_d;
            rd_q         <= rd_d;
            mis_q        <= mis_d;
            skip_q       <= skip_d;
            cnt_q        <= cnt_d;
        end
    end

    assign busy_o           = busy_q;
    assign mem_read_en_o    = mem_rd_q;
    assign mem_write_en_o   = mem_we_q;
    assign mem_addr_o       = mem_addr_q;
    assign mem_write_data_o = mem_wdata_q;
    assign resp_valid_o     = resp_valid_q;
    assign resp_data_o      = resp_data_q;
    assign resp_rd_o        = resp_rd_q;
    assign resp_err_o       = resp_err_q;
    assign resv_valid_o     = resv_valid_q;

endmodule

// File: tb/tb_mips_lsu.sv
// Randomized bench for mips_lsu against a transaction-level reference model.
module tb_mips_lsu;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned GLG    = 2;
    localparam int unsigned TMO    = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, req_valid, req_load, req_store, req_signed, req_ll, req_sc;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        busy_o, mem_read_en_o, resp_valid_o, resp_err_o, resv_valid_o;
    logic [3:0]  mem_write_en_o;
    logic [31:0] mem_addr_o, mem_write_data_o, resp_data_o;
    logic [4:0]  resp_rd_o;
    logic [31:0] mem_read_data, snoop_addr;
    logic        mem_ready, snoop_we;

    always #5 clk = ~clk;

    mips_lsu #(.ADDR_W(ADDR_W), .RESV_GRAN_LG(GLG), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .en_i(en),
        .req_valid_i(req_valid), .req_load_i(req_load), .req_store_i(req_store),
        .req_size_i(req_size), .req_signed_i(req_signed), .req_ll_i(req_ll), .req_sc_i(req_sc),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_rd_i(req_rd),
        .busy_o(busy_o), .mem_read_en_o(mem_read_en_o), .mem_write_en_o(mem_write_en_o),
        .mem_addr_o(mem_addr_o), .mem_write_data_o(mem_write_data_o),
        .mem_read_data_i(mem_read_data), .mem_ready_i(mem_ready),
        .snoop_we_i(snoop_we), .snoop_addr_i(snoop_addr),
        .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .resp_rd_o(resp_rd_o),
        .resp_err_o(resp_err_o), .resv_valid_o(resv_valid_o)
    );

    typedef struct {
        bit          ld, st, sg, ll, sc;
        logic [1:0]  sz;
        logic [31:0] a, wd, snoop_a;
        logic [4:0]  rd;
        int          waits, en_off, snoop_at;
    } req_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [0:1023];
    bit          resv_v;
    logic [31:0] resv_g;
    logic [31:0] last_data;
    logic        last_err;
    logic [3:0]  last_we;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit misaligned(input logic [31:0] a, input logic [1:0] sz);
        return (a % nbytes(sz)) != 0;
    endfunction

    function automatic logic [31:0] load_val(input logic [31:0] w, input logic [31:0] a,
                                             input logic [1:0] sz, input bit sg);
        int unsigned n, sh;
        logic [63:0] mask, v;
        n    = nbytes(sz);
        sh   = (4 - n - (a % 4)) * 8;
        mask = (64'd1 << (8 * n)) - 64'd1;
        v    = ({32'd0, w} >> sh) & mask;
        if (sg && n < 4 && v[8*n-1]) v = v | (64'h0000_0000_FFFF_FFFF & ~mask);
        return v[31:0];
    endfunction

    function automatic logic [3:0] lanes_m(input logic [31:0] a, input logic [1:0] sz);
        int unsigned n;
        n = nbytes(sz);
        return 4'(((32'd1 << n) - 32'd1) << (4 - n - (a % 4)));
    endfunction

    function automatic logic [31:0] wdata_m(input logic [31:0] w, input logic [1:0] sz);
        int unsigned n;
        n = nbytes(sz);
        if (n == 1) return (w & 32'hFF) * 32'h0101_0101;
        if (n == 2) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic bit resv_hit(input logic [31:0] a);
        return resv_v && ((a >> GLG) == resv_g);
    endfunction

    function automatic req_t mk(input bit ld, input bit st, input logic [1:0] sz, input bit sg,
                                input bit ll, input bit sc, input logic [31:0] a,
                                input logic [31:0] wd, input int waits);
        req_t r;
        r.ld = ld; r.st = st; r.sz = sz; r.sg = sg; r.ll = ll; r.sc = sc;
        r.a = a; r.wd = wd; r.rd = 5'($urandom_range(0, 31)); r.waits = waits;
        r.en_off = 0; r.snoop_at = -1; r.snoop_a = 32'd0;
        return r;
    endfunction

    // One full request; called on a falling edge, returns on a falling edge with the unit idle.
    task automatic xact(input req_t r);
        bit          mis, hit, sn0, skip, tmo, done;
        int          lat, edges, n;
        logic [9:0]  idx;
        logic [31:0] exp_data;
        logic [3:0]  exp_we;
        mis   = misaligned(r.a, r.sz);
        hit   = resv_hit(r.a);
        sn0   = (r.snoop_at == 0) && resv_hit(r.snoop_a);
        skip  = mis || (r.sc && !(hit && !sn0)) || !(r.ld || r.st);
        tmo   = !skip && (TMO != 0) && (r.waits >= int'(TMO));
        lat   = skip ? 1 : (tmo ? int'(TMO) : r.waits + 1);
        idx   = r.a[11:2];
        exp_we = (!skip && r.st) ? lanes_m(r.a, r.sz) : 4'b0000;
        exp_data = 32'd0;
        edges = 0; n = 0; done = 0; last_we = 4'b0000;

        en = 1'b1; req_valid = 1'b1; req_load = r.ld; req_store = r.st; req_size = r.sz;
        req_signed = r.sg; req_ll = r.ll; req_sc = r.sc; req_addr = r.a; req_wdata = r.wd;
        req_rd = r.rd; snoop_we = (r.snoop_at == 0); snoop_addr = r.snoop_a;
        mem_ready = 1'b0; mem_read_data = $urandom;
        @(posedge clk);
        if (sn0) resv_v = 1'b0;
        if (!skip && r.st && hit) resv_v = 1'b0;
        @(negedge clk);
        req_valid = 1'b0; snoop_we = 1'b0;

        while (!done) begin
            n++;
            if (n > lat + 8) begin
                check_eq("resp_missing", 32'(resp_valid_o), 32'd1);
                done = 1;
            end else if (edges == lat) begin
                check_eq("resp_valid", 32'(resp_valid_o), 32'd1);
                check_eq("resp_data", resp_data_o, exp_data);
                check_eq("resp_err", 32'(resp_err_o), 32'(mis || tmo));
                check_eq("resp_rd", 32'(resp_rd_o), 32'(r.rd));
                check_eq("resp_busy", 32'(busy_o), 32'd1);
                check_eq("resp_resv", 32'(resv_valid_o), 32'(resv_v));
                check_eq("resp_mem_idle", {27'd0, mem_read_en_o, mem_write_en_o}, 32'd0);
                last_data = resp_data_o; last_err = resp_err_o;
                done = 1;
            end else begin
                check_eq("early_valid", 32'(resp_valid_o), 32'd0);
                check_eq("busy", 32'(busy_o), 32'd1);
                check_eq("mem_rd", 32'(mem_read_en_o), 32'(!skip && r.ld));
                check_eq("mem_we", 32'(mem_write_en_o), 32'(exp_we));
                last_we = last_we | mem_write_en_o;
                if (!skip) check_eq("mem_addr", mem_addr_o, r.a);
                if (!skip && r.st) check_eq("mem_wdata", mem_write_data_o, wdata_m(r.wd, r.sz));
                en        = !(r.en_off > 0 && n >= r.en_off && n < r.en_off + 2);
                mem_ready = !skip && (edges >= r.waits);
                mem_read_data = mem_ready ? mem[idx] : $urandom;
                snoop_we  = (r.snoop_at == n);
                @(posedge clk);
                if (en) begin
                    if (snoop_we && resv_hit(r.snoop_a)) resv_v = 1'b0;
                    edges++;
                    if (edges == lat) begin
                        if (!(skip || tmo))
                            exp_data = r.ld ? load_val(mem[idx], r.a, r.sz, r.sg) : 32'(r.sc);
                        if (r.sc && !mis) resv_v = 1'b0;
                        if (r.ll && !skip && !tmo) begin
                            resv_v = 1'b1;
                            resv_g = r.a >> GLG;
                        end
                        if (r.st && !skip && !tmo)
                            for (int i = 0; i < 4; i++)
                                if (exp_we[3-i]) mem[idx][31-8*i -: 8] = wdata_m(r.wd, r.sz) >> (24 - 8*i);
                    end
                end
                @(negedge clk);
                snoop_we = 1'b0; mem_ready = 1'b0;
            end
        end
        en = 1'b1; mem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("pulse_end", 32'(resp_valid_o), 32'd0);
        check_eq("idle_busy", 32'(busy_o), 32'd0);
    endtask

    task automatic idle(input bit sw, input logic [31:0] sa);
        req_valid = 1'b0; en = 1'b1; snoop_we = sw; snoop_addr = sa;
        @(posedge clk);
        if (sw && resv_hit(sa)) resv_v = 1'b0;
        @(negedge clk);
        snoop_we = 1'b0;
        check_eq("idle_resv", 32'(resv_valid_o), 32'(resv_v));
    endtask

    initial begin
        req_t r;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        rst_n = 1'b0; en = 1'b0; req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
        req_size = 2'd0; req_signed = 1'b0; req_ll = 1'b0; req_sc = 1'b0; req_addr = 32'd0;
        req_wdata = 32'd0; req_rd = 5'd0; mem_read_data = 32'd0; mem_ready = 1'b0;
        snoop_we = 1'b0; snoop_addr = 32'd0; resv_v = 1'b0; resv_g = 32'd0;
        last_data = 32'd0; last_err = 1'b0; last_we = 4'b0000;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_resp", {30'd0, resp_valid_o, resp_err_o}, 32'd0);
        check_eq("rst_data", resp_data_o, 32'd0);
        check_eq("rst_mem", {27'd0, mem_read_en_o, mem_write_en_o}, 32'd0);
        check_eq("rst_addr", mem_addr_o, 32'd0);
        check_eq("rst_resv", 32'(resv_valid_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        mem[10'h040] = 32'h11A2_B3C4;
        xact(mk(1, 0, 2'd0, 1, 0, 0, 32'h101, 32'd0, 0));
        check_eq("lb_ex", last_data, 32'hFFFF_FFA2);
        xact(mk(1, 0, 2'd0, 0, 0, 0, 32'h101, 32'd0, 0));
        check_eq("lbu_ex", last_data, 32'h0000_00A2);
        xact(mk(0, 1, 2'd1, 0, 0, 0, 32'h202, 32'h0000_1234, 0));
        check_eq("sh_we", 32'(last_we), 32'h3);
        xact(mk(0, 1, 2'd0, 0, 0, 0, 32'h203, 32'h0000_0056, 1));
        check_eq("sb_we", 32'(last_we), 32'h1);
        xact(mk(1, 0, 2'd2, 0, 0, 0, 32'h6, 32'd0, 0));
        check_eq("lw_mis_err", 32'(last_err), 32'd1);

        xact(mk(1, 0, 2'd2, 0, 1, 0, 32'h400, 32'd0, 0));
        xact(mk(0, 1, 2'd2, 0, 0, 1, 32'h400, 32'hDEAD_BEEF, 0));
        check_eq("sc_ok", last_data, 32'd1);
        check_eq("sc_ok_we", 32'(last_we), 32'hF);
        xact(mk(1, 0, 2'd2, 0, 1, 0, 32'h400, 32'd0, 1));
        idle(1'b1, 32'h402);
        xact(mk(0, 1, 2'd2, 0, 0, 1, 32'h400, 32'h1234_5678, 0));
        check_eq("sc_snooped", last_data, 32'd0);
        check_eq("sc_snooped_we", 32'(last_we), 32'h0);

        xact(mk(1, 0, 2'd2, 0, 1, 0, 32'h500, 32'd0, 100));
        check_eq("ll_tmo_err", 32'(last_err), 32'd1);
        check_eq("ll_tmo_resv", 32'(resv_valid_o), 32'd0);

        r = mk(1, 0, 2'd2, 0, 0, 0, 32'h120, 32'd0, 5);
        r.en_off = 3;
        xact(r);
        r = mk(1, 0, 2'd2, 0, 1, 0, 32'h600, 32'd0, 2);
        r.snoop_at = 1; r.snoop_a = 32'h600;
        xact(r);
        check_eq("ll_snoop_resv", 32'(resv_valid_o), 32'd1);

        // Reset in the middle of a waiting access.
        req_valid = 1'b1; req_load = 1'b1; req_store = 1'b0; req_size = 2'd2; req_ll = 1'b0;
        req_sc = 1'b0; req_addr = 32'h124;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        resv_v = 1'b0;
        check_eq("mid_rst_busy", 32'(busy_o), 32'd0);
        check_eq("mid_rst_mem", {27'd0, mem_read_en_o, mem_write_en_o}, 32'd0);
        check_eq("mid_rst_resv", 32'(resv_valid_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("post_rst_valid", 32'(resp_valid_o), 32'd0);
            check_eq("post_rst_busy", 32'(busy_o), 32'd0);
        end
        mem_ready = 1'b0;

        for (int i = 0; i < 300; i++) begin
            int kind;
            kind = int'($urandom_range(0, 5));
            r = mk(kind < 2 || kind == 4, kind == 2 || kind == 3 || kind == 5,
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), kind == 4, kind == 5,
                   32'd0, $urandom, int'($urandom_range(0, TMO + 1)));
            if (r.ll || r.sc) r.sz = 2'd2;
            r.a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4095))
                                               : 32'h400 + 32'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) r.a = r.a & ~(32'(nbytes(r.sz)) - 32'd1);
            if ($urandom_range(0, 3) == 0) r.en_off = int'($urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) r.snoop_at = int'($urandom_range(0, 3));
            r.snoop_a = 32'h400 + 32'($urandom_range(0, 15));
            xact(r);
            if ($urandom_range(0, 4) == 0) idle(1'($urandom_range(0, 1)), 32'h400 + 32'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
